// File: rtl/sha_compression_core_if.sv
// Block request, message-word and digest channels of the SHA-256 compression core.
interface sha_compression_core_if;
  logic             start_valid;
  logic             start_ready;
  logic [7:0][31:0] H_i;
  logic             w_valid;
  logic [31:0]      w_i;
  logic             w_ready;
  logic [5:0]       round_o;
  logic             digest_valid;
  logic             digest_ready;
  logic [7:0][31:0] digest_o;

  modport master (
    output start_valid, H_i, w_valid, w_i, digest_ready,
    input  start_ready, w_ready, round_o, digest_valid, digest_o
  );

  modport slave (
    input  start_valid, H_i, w_valid, w_i, digest_ready,
    output start_ready, w_ready, round_o, digest_valid, digest_o
  );
endinterface

// File: rtl/sha_compression_core.sv
// SHA-256 compression: one round per accepted schedule word, then an optional
// feed-forward of the chaining value into a held digest.
module sha_compression_core #(
  parameter int unsigned FEEDFORWARD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sha_compression_core_if.slave bus
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ROUND_W = 6;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [WORD_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  state_t                   state_q, state_d;
  logic [ROUND_W-1:0]       t_q, t_d;
  logic [7:0][WORD_W-1:0]   work_q, work_d;
  logic [7:0][WORD_W-1:0]   hs_q, hs_d;
  logic [7:0][WORD_W-1:0]   digest_q, digest_d;
  logic [7:0][WORD_W-1:0]   round_res, final_res;
  logic                     start_ready_q, w_ready_q, digest_valid_q;
  logic [ROUND_W-1:0]       round_q;

  // One SHA-256 round on the current working state and schedule word
  always_comb begin
    logic [WORD_W-1:0] s0, s1, ch, maj, t1, t2;
    s1  = rotr(work_q[4], 6) ^ rotr(work_q[4], 11) ^ rotr(work_q[4], 25);
    ch  = (work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]);
    t1  = work_q[7] + s1 + ch + K[t_q] + bus.w_i;
    s0  = rotr(work_q[0], 2) ^ rotr(work_q[0], 13) ^ rotr(work_q[0], 22);
    maj = (work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]);
    t2  = s0 + maj;
    round_res[0] = t1 + t2;
    round_res[1] = work_q[0];
    round_res[2] = work_q[1];
    round_res[3] = work_q[2];
    round_res[4] = work_q[3] + t1;
    round_res[5] = work_q[4];
    round_res[6] = work_q[5];
    round_res[7] = work_q[6];
  end

  always_comb begin
    final_res = work_q;
    for (int i = 0; i < 8; i++) begin
      if (FEEDFORWARD != 0) final_res[i] = hs_q[i] + work_q[i];
    end
  end

  // Next-state and datapath load decisions
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    work_d   = work_q;
    hs_d     = hs_q;
    digest_d = digest_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          state_d = ROUND;
          work_d  = bus.H_i;
          hs_d    = bus.H_i;
          t_d     = '0;
        end
      end
      ROUND: begin
        if (bus.w_valid) begin
          work_d = round_res;
          t_d    = t_q + ROUND_W'(1);
          if (t_q == ROUND_W'(63)) state_d = FINAL;
        end
      end
      FINAL: begin
        digest_d = final_res;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.digest_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      t_q            <= '0;
      work_q         <= '0;
      hs_q           <= '0;
      digest_q       <= '0;
      start_ready_q  <= 1'b1;
      w_ready_q      <= 1'b0;
      digest_valid_q <= 1'b0;
      round_q        <= '0;
    end else begin
      state_q        <= state_d;
      t_q            <= t_d;
      work_q         <= work_d;
      hs_q           <= hs_d;
      digest_q       <= digest_d;
      start_ready_q  <= (state_d == IDLE);
      w_ready_q      <= (state_d == ROUND);
      digest_valid_q <= (state_d == DONE);
      round_q        <= (state_d == ROUND) ? t_d : '0;
    end
  end

  assign bus.start_ready  = start_ready_q;
  assign bus.w_ready      = w_ready_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.round_o      = round_q;
  assign bus.digest_o     = digest_q;

endmodule

// File: tb/tb_sha_compression_core.sv
// Scoreboarded bench: two cores (feed-forward on and off) driven in lockstep with the "abc" block.
module tb_sha_compression_core;

  typedef logic [7:0][31:0] dig_t;
  typedef struct {
    dig_t d;
    int   acc;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha_compression_core_if ifc1 ();
  sha_compression_core_if ifc0 ();

  assign ifc0.start_valid  = ifc1.start_valid;
  assign ifc0.H_i          = ifc1.H_i;
  assign ifc0.w_valid      = ifc1.w_valid;
  assign ifc0.w_i          = ifc1.w_i;
  assign ifc0.digest_ready = ifc1.digest_ready;

  sha_compression_core #(.FEEDFORWARD(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
  sha_compression_core #(.FEEDFORWARD(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q1[$];
  exp_t q0[$];
  bit   prev_dv[2] = '{1'b0, 1'b0};
  dig_t held[2];
  logic [31:0] W [64];
  dig_t iv, ref1, ref0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Scoreboard monitor for one core
  task automatic mon(input int idx, input logic dv, input dig_t dg, input logic sr);
    exp_t e;
    bit   have;
    if (dv && !prev_dv[idx]) begin
      have = (idx == 1) ? (q1.size() != 0) : (q0.size() != 0);
      if (!have) begin
        checks++;
        failures++;
        $display("FAIL unexpected_digest core=%0d actual=%0h required=none", idx, dg);
      end else begin
        if (idx == 1) e = q1.pop_front();
        else          e = q0.pop_front();
        chk($sformatf("digest_ff%0d", idx), 256'(dg), 256'(e.d));
        chk($sformatf("latency_ff%0d", idx), 256'(cyc - e.acc), 256'(e.lat));
      end
      held[idx] = dg;
    end else if (dv) begin
      chk($sformatf("digest_stable_ff%0d", idx), 256'(dg), 256'(held[idx]));
      chk($sformatf("start_ready_in_done_ff%0d", idx), 256'(sr), 256'(0));
    end
    prev_dv[idx] = dv;
  endtask

  always @(negedge clk) begin
    mon(1, ifc1.digest_valid, ifc1.digest_o, ifc1.start_ready);
    mon(0, ifc0.digest_valid, ifc0.digest_o, ifc0.start_ready);
  end

  function automatic int stall_of(input int k);
    case (k)
      0:       return 2;
      17:      return 1;
      40:      return 5;
      63:      return 3;
      default: return 0;
    endcase
  endfunction

  // Present start until accepted; pushes expectations at the acceptance edge
  task automatic start_block(input int lat, input bit keep, output int acc);
    bit done = 1'b0;
    acc = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      ifc1.start_valid = 1'b1;
      if (ifc1.start_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        q1.push_back('{ref1, cyc, lat});
        q0.push_back('{ref0, cyc, lat});
        done = 1'b1;
      end
    end
    if (!done) chk("start_timeout", 256'(0), 256'(1));
    if (!keep) ifc1.start_valid = 1'b0;
  endtask

  // Upstream word source; stalls are inserted before selected words
  task automatic feed(input bit stalls, input int nw);
    for (int k = 0; k < nw; k++) begin
      int ns = stalls ? stall_of(k) : 0;
      for (int s = 0; s < ns; s++) begin
        @(negedge clk);
        ifc1.w_valid = 1'b0;
        ifc1.w_i     = 32'hdeadbeef;
        chk("round_frozen", 256'(ifc1.round_o), 256'(k));
      end
      @(negedge clk);
      ifc1.w_valid = 1'b1;
      ifc1.w_i     = W[k];
      chk("round_o", 256'(ifc1.round_o), 256'(k));
      chk("w_ready", 256'(ifc1.w_ready), 256'(1));
    end
    @(posedge clk);
    #1;
    ifc1.w_valid = 1'b0;
    ifc1.w_i     = 32'hdeadbeef;
  endtask

  task automatic wait_done(output int hs);
    bit done = 1'b0;
    hs = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (ifc1.digest_valid && ifc1.digest_ready) begin
        @(posedge clk);
        #1;
        hs = cyc;
        done = 1'b1;
      end
    end
    if (!done) chk("digest_timeout", 256'(0), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, hs, acc2;
    logic [7:0] msg [64];
    iv   = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
            32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    ref1 = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
            32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
    for (int i = 0; i < 8; i++) ref0[i] = ref1[i] - iv[i];
    for (int i = 0; i < 64; i++) msg[i] = 8'h00;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h80; msg[63] = 8'h18;
    for (int i = 0; i < 16; i++) W[i] = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
    for (int i = 16; i < 64; i++)
      W[i] = (rr(W[i-2], 17) ^ rr(W[i-2], 19) ^ (W[i-2] >> 10)) + W[i-7]
           + (rr(W[i-15], 7) ^ rr(W[i-15], 18) ^ (W[i-15] >> 3)) + W[i-16];

    rst               = 1'b1;
    ifc1.start_valid  = 1'b0;
    ifc1.H_i          = iv;
    ifc1.w_valid      = 1'b0;
    ifc1.w_i          = '0;
    ifc1.digest_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_start_ready", 256'(ifc1.start_ready), 256'(1));
    chk("rst_w_ready", 256'(ifc1.w_ready), 256'(0));
    chk("rst_digest_valid", 256'(ifc1.digest_valid), 256'(0));
    chk("rst_round_o", 256'(ifc1.round_o), 256'(0));
    chk("rst_digest_o", 256'(ifc1.digest_o), 256'(0));
    rst = 1'b0;

    // Plain "abc" block
    start_block(65, 1'b0, acc);
    feed(1'b0, 64);
    wait_done(hs);

    // Stalls including before round 0 and round 63
    start_block(65 + 11, 1'b0, acc);
    feed(1'b1, 64);
    wait_done(hs);

    // Reset at round 30 with every other input asserted
    start_block(65, 1'b0, acc);
    feed(1'b0, 30);
    @(negedge clk);
    chk("round_before_rst", 256'(ifc1.round_o), 256'(30));
    rst = 1'b1; ifc1.w_valid = 1'b1; ifc1.w_i = W[30]; ifc1.start_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; ifc1.w_valid = 1'b0; ifc1.start_valid = 1'b0;
    chk("midrst_start_ready", 256'(ifc1.start_ready), 256'(1));
    chk("midrst_digest_valid", 256'(ifc1.digest_valid), 256'(0));
    chk("midrst_round_o", 256'(ifc1.round_o), 256'(0));
    chk("midrst_w_ready", 256'(ifc1.w_ready), 256'(0));
    chk("midrst_digest_o", 256'(ifc1.digest_o), 256'(0));
    q1.delete();
    q0.delete();
    start_block(65, 1'b0, acc);
    feed(1'b0, 64);
    wait_done(hs);

    // Digest backpressure with ignored start pulses
    ifc1.digest_ready = 1'b0;
    start_block(65, 1'b0, acc);
    feed(1'b0, 64);
    for (int n = 0; n < 10 && !ifc1.digest_valid; n++) @(negedge clk);
    chk("bp_digest_valid", 256'(ifc1.digest_valid), 256'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ifc1.start_valid = (i % 2 == 0);
      chk("bp_start_ready", 256'(ifc1.start_ready), 256'(0));
      chk("bp_valid_held", 256'(ifc1.digest_valid), 256'(1));
    end
    @(negedge clk);
    ifc1.start_valid  = 1'b0;
    ifc1.digest_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 256'(ifc1.digest_valid), 256'(0));
    chk("bp_release_idle", 256'(ifc1.start_ready), 256'(1));

    // Back-to-back with start_valid held high
    start_block(65, 1'b1, acc);
    feed(1'b0, 64);
    wait_done(hs);
    start_block(65, 1'b1, acc2);
    chk("b2b_gap", 256'((acc2 - hs) >= 1), 256'(1));
    ifc1.start_valid = 1'b0;
    feed(1'b0, 64);
    wait_done(hs);

    repeat (3) @(negedge clk);
    chk("queue1_drained", 256'(q1.size()), 256'(0));
    chk("queue0_drained", 256'(q0.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
